flag_demux_reg: RTL
===================

// Module: flag_demux_reg
// PURPOSE
//  Inverse of the 2:1 flag mux: routes one 4-bit status-flag stream from the
//  shared arithmetic unit to one of two destination channels (A/B), chosen by sel.
//  Each channel holds its flags in a register until the consumer acknowledges.
//  Each channel also keeps a saturating count of overruns (unacknowledged
//  updates that were merged or overwritten).
//  Sits between the arithmetic core flag output and the two result/display paths.
// PARAMETERS
//  FLAG_W   4   flag vector width
//  CNT_W    3   overrun counter width per channel (saturating)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous reset, active-low
//  flag_in      in   FLAG_W   flag vector from arithmetic unit
//  flag_valid   in   1        flag_in valid this cycle (single-cycle strobe)
//  sel          in   1        destination: 0 = channel A, 1 = channel B
//  ack_a        in   1        channel A consumer has read flag_a_out
//  ack_b        in   1        channel B consumer has read flag_b_out
//  flag_a_out   out  FLAG_W   registered channel A flags
//  flag_b_out   out  FLAG_W   registered channel B flags
//  pend_a       out  1        channel A holds unacknowledged flags
//  pend_b       out  1        channel B holds unacknowledged flags
//  ovr_a        out  CNT_W    channel A overrun count
//  ovr_b        out  CNT_W    channel B overrun count
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset: all outputs 0. Both channel FSMs go to IDLE. Reset mid-PEND discards
//    the held flags.
//  - Channel x is written ("wr_x") when flag_valid=1 and sel selects x.
//    The other channel is never affected.
//  - Latency: a write is visible on flag_x_out and pend_x on the next clk edge.
//  - Per-channel FSM, two states:
//      IDLE: wr_x with flag_in!=0 -> PEND; flag_x_out<=flag_in; ovr_x<=0.
//            wr_x with flag_in==0 -> stay IDLE; no change.
//            ack_x in IDLE is ignored.
//      PEND: ack_x only -> IDLE; flag_x_out<=0; ovr_x<=0.
//            wr_x only  -> stay PEND; merge the update (see CONFIGURATION);
//                          ovr_x<=ovr_x+1, saturating at 2^CNT_W-1.
//            ack_x and wr_x in the same cycle -> ack takes effect first, then
//                          the write is applied as if in IDLE (new flags,
//                          ovr_x<=0; flag_in==0 -> IDLE with outputs cleared).
//  - pend_x = (state_x == PEND); it is a registered output.
//  - Both channels update independently in the same cycle (e.g. ack_a during wr_b).
// CONFIGURATION
//  FLAG_DEMUX_STICKY_EN defined:
//    PEND write ORs the new flags in: flag_x_out <= flag_x_out | flag_in.
//    No flag is lost until acknowledged.
//  FLAG_DEMUX_STICKY_EN undefined (default):
//    PEND write overwrites: flag_x_out <= flag_in.
//    A zero flag_in in PEND still counts as an overrun.
//    Channel stays PEND with flags 0 until ack.
//  ovr_x counting is identical in both builds.
// TESTING
//  1. Reset mid-op: rst_n low with pend_a=1 -> all outputs 0 at once
//     (asynchronous), before the next clk edge.
//  2. Write A with flag_in=4'b0101 -> next cycle flag_a_out=0101, pend_a=1;
//     channel B is unchanged.
//     Then ack_a -> next cycle flag_a_out=0, pend_a=0.
//  3. A in PEND with 0001, then writes 0010 and 1000 with no ack:
//     - sticky build: flag_a_out=1011, ovr_a=2.
//     - default build: flag_a_out=1000, ovr_a=2.
//  4. 10 unacknowledged writes to B while PEND -> ovr_b saturates at 7 (CNT_W=3)
//     and does not wrap.
//  5. ack_b and a write to B of 0100 in the same cycle while B is PEND with
//     ovr_b=3 -> flag_b_out=0100, pend_b=1, ovr_b=0.
//     Same with flag_in=0 -> pend_b=0, flag_b_out=0.
//  6. Same-cycle ack_a and a write to B (sel=1, 0110) -> A clears and B loads
//     0110 independently.

Source files
------------

// File: rtl/flag_demux_reg.sv
// Routes one flag stream to channel A or B; each channel holds until ack.
// Optional FLAG_DEMUX_STICKY_EN: PEND writes OR into held flags.
module flag_demux_chan #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              ack,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [FLAG_W-1:0] flag_out,
  output logic              pend,
  output logic [CNT_W-1:0]  ovr
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state_q, state_d;
  logic [FLAG_W-1:0]  flag_d;
  logic [CNT_W-1:0]   ovr_d;
  logic               nz;

  assign nz = |flag_in;

  // state, flags and overrun count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flag_out <= '0;
      ovr      <= '0;
    end else begin
      state_q  <= state_d;
      flag_out <= flag_d;
      ovr      <= ovr_d;
    end
  end

  // next state: ack first, then write as if idle; else merge and count
  always_comb begin
    state_d = state_q;
    flag_d  = flag_out;
    ovr_d   = ovr;
    unique case (state_q)
      IDLE: begin
        if (wr && nz) begin
          state_d = PEND;
          flag_d  = flag_in;
          ovr_d   = '0;
        end
      end
      PEND: begin
        if (ack) begin
          if (wr && nz) begin
            state_d = PEND;
            flag_d  = flag_in;
          end else begin
            state_d = IDLE;
            flag_d  = '0;
          end
          ovr_d = '0;
        end else if (wr) begin
`ifdef FLAG_DEMUX_STICKY_EN
          flag_d = flag_out | flag_in;
`else
          flag_d = flag_in;
`endif
          if (ovr != {CNT_W{1'b1}})
            ovr_d = ovr + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        flag_d  = '0;
        ovr_d   = '0;
      end
    endcase
  end

  assign pend = (state_q == PEND);

endmodule

module flag_demux_reg #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic              flag_valid,
  input  logic              sel,
  input  logic              ack_a,
  input  logic              ack_b,
  output logic [FLAG_W-1:0] flag_a_out,
  output logic [FLAG_W-1:0] flag_b_out,
  output logic              pend_a,
  output logic              pend_b,
  output logic [CNT_W-1:0]  ovr_a,
  output logic [CNT_W-1:0]  ovr_b
);

  logic wr_a, wr_b;

  assign wr_a = flag_valid & ~sel;
  assign wr_b = flag_valid &  sel;

  flag_demux_chan #(.FLAG_W(FLAG_W), .CNT_W(CNT_W)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr_a),
    .ack      (ack_a),
    .flag_in  (flag_in),
    .flag_out (flag_a_out),
    .pend     (pend_a),
    .ovr      (ovr_a)
  );

  flag_demux_chan #(.FLAG_W(FLAG_W), .CNT_W(CNT_W)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr_b),
    .ack      (ack_b),
    .flag_in  (flag_in),
    .flag_out (flag_b_out),
    .pend     (pend_b),
    .ovr      (ovr_b)
  );

endmodule
